// File: rtl/ac_motor_spwm_if.sv
// Bus between the SPWM core and its environment: ramp and carrier inputs, then
// V/f state, sine values and PWM outputs.
interface ac_motor_spwm_if;
  logic [11:0] power;
  logic [15:0] mod_delay_umin;
  logic [23:0] triangle;
  logic        modulation;
  logic [7:0]  delay;
  logic [11:0] frequency;
  logic [11:0] amplitude;
  logic        lock;
  logic [23:0] sine_val_1;
  logic [23:0] sine_val_2;
  logic [23:0] sine_val_3;
  logic        s1;
  logic        s2;
  logic        s3;

  modport master (
    output power, mod_delay_umin, triangle,
    input  modulation, delay, frequency, amplitude, lock,
    input  sine_val_1, sine_val_2, sine_val_3, s1, s2, s3
  );

  modport slave (
    input  power, mod_delay_umin, triangle,
    output modulation, delay, frequency, amplitude, lock,
    output sine_val_1, sine_val_2, sine_val_3, s1, s2, s3
  );
endinterface

// File: rtl/ac_motor_spwm_core.sv
// Three-phase sine-PWM core: V/f ramp -> phase accumulator -> sine LUT x amplitude -> carrier compare.
// Latency: frequency +1 clk to amplitude, phase +1 clk to sine, sine +1 clk to s1..s3; no backpressure.
module ac_motor_spwm_core #(
  parameter logic [7:0]  DEAD_TIME = 8'd16,
  parameter logic [11:0] AMP_MIN   = 12'd205
) (
  input logic            clk,
  input logic            rst_n,
  ac_motor_spwm_if.slave bus
);

  localparam logic [23:0] SINE_MID = 24'h800000;

  logic [15:0]       cnt_q, cnt_d;
  logic [11:0]       freq_q, freq_d;
  logic [11:0]       amp_q, amp_d;
  logic              mod_q, mod_d;
  logic [23:0]       acc_q, acc_d;
  logic              lock_q, lock_d;
  logic [2:0][23:0]  sine_q, sine_d;
  logic [2:0]        s_q, s_d;
  logic [2:0][7:0]   idx;

  // Quarter-wave table: round(2047*sin(2*pi*j/256)) for j = 0..64.
  function automatic logic [10:0] quarter(input logic [6:0] j);
    case (j)
      7'd0:  quarter = 11'd0;    7'd1:  quarter = 11'd50;   7'd2:  quarter = 11'd100;
      7'd3:  quarter = 11'd151;  7'd4:  quarter = 11'd201;  7'd5:  quarter = 11'd251;
      7'd6:  quarter = 11'd300;  7'd7:  quarter = 11'd350;  7'd8:  quarter = 11'd399;
      7'd9:  quarter = 11'd449;  7'd10: quarter = 11'd497;  7'd11: quarter = 11'd546;
      7'd12: quarter = 11'd594;  7'd13: quarter = 11'd642;  7'd14: quarter = 11'd690;
      7'd15: quarter = 11'd737;  7'd16: quarter = 11'd783;  7'd17: quarter = 11'd830;
      7'd18: quarter = 11'd875;  7'd19: quarter = 11'd920;  7'd20: quarter = 11'd965;
      7'd21: quarter = 11'd1009; 7'd22: quarter = 11'd1052; 7'd23: quarter = 11'd1095;
      7'd24: quarter = 11'd1137; 7'd25: quarter = 11'd1179; 7'd26: quarter = 11'd1219;
      7'd27: quarter = 11'd1259; 7'd28: quarter = 11'd1299; 7'd29: quarter = 11'd1337;
      7'd30: quarter = 11'd1375; 7'd31: quarter = 11'd1411; 7'd32: quarter = 11'd1447;
      7'd33: quarter = 11'd1483; 7'd34: quarter = 11'd1517; 7'd35: quarter = 11'd1550;
      7'd36: quarter = 11'd1582; 7'd37: quarter = 11'd1614; 7'd38: quarter = 11'd1644;
      7'd39: quarter = 11'd1674; 7'd40: quarter = 11'd1702; 7'd41: quarter = 11'd1729;
      7'd42: quarter = 11'd1756; 7'd43: quarter = 11'd1781; 7'd44: quarter = 11'd1805;
      7'd45: quarter = 11'd1828; 7'd46: quarter = 11'd1850; 7'd47: quarter = 11'd1871;
      7'd48: quarter = 11'd1891; 7'd49: quarter = 11'd1910; 7'd50: quarter = 11'd1927;
      7'd51: quarter = 11'd1944; 7'd52: quarter = 11'd1959; 7'd53: quarter = 11'd1973;
      7'd54: quarter = 11'd1986; 7'd55: quarter = 11'd1997; 7'd56: quarter = 11'd2008;
      7'd57: quarter = 11'd2017; 7'd58: quarter = 11'd2025; 7'd59: quarter = 11'd2032;
      7'd60: quarter = 11'd2037; 7'd61: quarter = 11'd2041; 7'd62: quarter = 11'd2045;
      7'd63: quarter = 11'd2046; 7'd64: quarter = 11'd2047;
      default: quarter = 11'd0;
    endcase
  endfunction

  // idx[6] mirrors the quarter, idx[7] negates the half.
  function automatic logic signed [11:0] sin12(input logic [7:0] i);
    logic [6:0]  j;
    logic [10:0] mag;
    j   = i[6] ? (7'd64 - {1'b0, i[5:0]}) : {1'b0, i[5:0]};
    mag = quarter(j);
    sin12 = i[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  always_comb begin
    cnt_d  = cnt_q;
    freq_d = freq_q;
    if (bus.mod_delay_umin == 16'd0) begin
      cnt_d  = 16'd0;
      freq_d = bus.power;
    end else if (({1'b0, cnt_q} + 17'd1) >= {1'b0, bus.mod_delay_umin}) begin
      // >= rather than == so a shortened interval takes effect without a 64k wrap.
      cnt_d = 16'd0;
      if (freq_q < bus.power) begin
        freq_d = freq_q + 12'd1;
      end else if (freq_q > bus.power) begin
        freq_d = freq_q - 12'd1;
      end
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_comb begin
    amp_d = 12'd0;
    if (freq_q != 12'd0) begin
      amp_d = (freq_q > AMP_MIN) ? freq_q : AMP_MIN;
    end
    mod_d = (freq_q != 12'd0);
    {lock_d, acc_d} = {1'b0, acc_q} + {13'd0, freq_q};
  end

  always_comb begin
    logic signed [24:0] prod;
    idx[0] = acc_q[23:16];
    idx[1] = 8'((acc_q + 24'h555555) >> 16);
    idx[2] = 8'((acc_q + 24'hAAAAAA) >> 16);
    sine_d = sine_q;
    s_d    = s_q;
    prod   = 25'sd0;
    for (int n = 0; n < 3; n++) begin
      // |sin12 * amp| < 2^23, so the low 24 bits added to mid-scale cannot wrap.
      prod      = sin12(idx[n]) * $signed({1'b0, amp_q});
      sine_d[n] = SINE_MID + prod[23:0];
      s_d[n]    = (sine_q[n] > bus.triangle);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 16'd0;
      freq_q <= 12'd0;
      amp_q  <= 12'd0;
      mod_q  <= 1'b0;
      acc_q  <= 24'd0;
      lock_q <= 1'b0;
      sine_q <= {3{SINE_MID}};
      s_q    <= 3'b000;
    end else begin
      cnt_q  <= cnt_d;
      freq_q <= freq_d;
      amp_q  <= amp_d;
      mod_q  <= mod_d;
      acc_q  <= acc_d;
      lock_q <= lock_d;
      sine_q <= sine_d;
      s_q    <= s_d;
    end
  end

  assign bus.modulation = mod_q;
  assign bus.delay      = DEAD_TIME;
  assign bus.frequency  = freq_q;
  assign bus.amplitude  = amp_q;
  assign bus.lock       = lock_q;
  assign bus.sine_val_1 = sine_q[0];
  assign bus.sine_val_2 = sine_q[1];
  assign bus.sine_val_3 = sine_q[2];
  assign bus.s1         = s_q[0];
  assign bus.s2         = s_q[1];
  assign bus.s3         = s_q[2];

endmodule

// File: tb/tb_ac_motor_spwm_core.sv
// Directed bench for ac_motor_spwm_core: ramp, V/f amplitude, lock period, sine peaks, comparator.
module tb_ac_motor_spwm_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ac_motor_spwm_if bus ();

  ac_motor_spwm_core dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Releases reset mid-cycle; the next rising edge is edge 1.
  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  function automatic logic [23:0] exp_sine(input int s, input int a);
    int v;
    v = 32'h800000 + s * a;
    return v[23:0];
  endfunction

  initial begin
    int first_lock;
    int second_lock;
    int wide_lock;
    logic prev_lock;

    bus.power          = 12'd4095;
    bus.mod_delay_umin = 16'd0;
    bus.triangle       = 24'd0;
    do_reset();
    check("rst_delay", 32'(bus.delay), 32'd16);
    check("rst_sine1", 32'(bus.sine_val_1), 32'h800000);

    // Full-speed step, lock period and sine peaks.
    tick();
    check("step_freq", 32'(bus.frequency), 32'd4095);
    check("step_amp0", 32'(bus.amplitude), 32'd0);
    check("step_mod0", 32'(bus.modulation), 32'd0);
    tick();
    check("step_amp",  32'(bus.amplitude), 32'd4095);
    check("step_mod",  32'(bus.modulation), 32'd1);
    first_lock  = 0;
    second_lock = 0;
    wide_lock   = 0;
    prev_lock   = 1'b0;
    for (int k = 3; k <= 8200; k++) begin
      tick();
      if (k == 3) check("sine_idx0", 32'(bus.sine_val_1), 32'h800000);
      if (k == 1032) begin
        check("sine1_idx64",  32'(bus.sine_val_1), 32'hFFE801);
        check("sine2_idx149", 32'(bus.sine_val_2), 32'(exp_sine(-1009, 4095)));
        check("sine3_idx235", 32'(bus.sine_val_3), 32'(exp_sine(-1009, 4095)));
      end
      if (k == 3082) begin
        check("sine1_idx192", 32'(bus.sine_val_1), 32'h0017FF);
        check("sine2_idx21",  32'(bus.sine_val_2), 32'(exp_sine(1009, 4095)));
        check("sine3_idx107", 32'(bus.sine_val_3), 32'(exp_sine(1009, 4095)));
      end
      if (bus.lock) begin
        if (prev_lock) wide_lock++;
        if (first_lock == 0) first_lock = k;
        else if (second_lock == 0) second_lock = k;
      end
      prev_lock = bus.lock;
    end
    check("lock_first",  32'(first_lock), 32'd4099);
    check("lock_second", 32'(second_lock), 32'd8196);
    check("lock_width",  32'(wide_lock), 32'd0);

    // Asynchronous reset mid-run takes effect without a clock edge.
    rst_n = 1'b0;
    #2;
    check("arst_freq",  32'(bus.frequency), 32'd0);
    check("arst_amp",   32'(bus.amplitude), 32'd0);
    check("arst_mod",   32'(bus.modulation), 32'd0);
    check("arst_lock",  32'(bus.lock), 32'd0);
    check("arst_s",     32'({bus.s1, bus.s2, bus.s3}), 32'd0);
    check("arst_sine1", 32'(bus.sine_val_1), 32'h800000);
    check("arst_sine2", 32'(bus.sine_val_2), 32'h800000);
    check("arst_sine3", 32'(bus.sine_val_3), 32'h800000);
    check("arst_delay", 32'(bus.delay), 32'd16);

    // Slow ramp to 100, then retarget down to 98.
    bus.power          = 12'd100;
    bus.mod_delay_umin = 16'd10;
    do_reset();
    for (int k = 1; k <= 1040; k++) begin
      tick();
      case (k)
        9:    check("ramp_f9",    32'(bus.frequency), 32'd0);
        10:   check("ramp_f10",   32'(bus.frequency), 32'd1);
        11: begin
          check("ramp_amp11", 32'(bus.amplitude), 32'd205);
          check("ramp_mod11", 32'(bus.modulation), 32'd1);
        end
        55:   check("ramp_f55",   32'(bus.frequency), 32'd5);
        1000: check("ramp_f1000", 32'(bus.frequency), 32'd100);
        1010: begin
          check("ramp_hold",  32'(bus.frequency), 32'd100);
          check("ramp_amp",   32'(bus.amplitude), 32'd205);
          bus.power = 12'd98;
        end
        1019: check("down_f1019", 32'(bus.frequency), 32'd100);
        1020: check("down_f1020", 32'(bus.frequency), 32'd99);
        1030: check("down_f1030", 32'(bus.frequency), 32'd98);
        1040: check("down_f1040", 32'(bus.frequency), 32'd98);
        default: ;
      endcase
    end

    // Comparator at zero amplitude, then V/f boost from a small step.
    bus.power          = 12'd0;
    bus.mod_delay_umin = 16'd0;
    bus.triangle       = 24'h800000;
    do_reset();
    tick();
    check("cmp_equal",  32'({bus.s1, bus.s2, bus.s3}), 32'd0);
    check("cmp_lock0",  32'(bus.lock), 32'd0);
    check("cmp_mod0",   32'(bus.modulation), 32'd0);
    bus.triangle = 24'h7FFFFF;
    tick();
    check("cmp_below",  32'({bus.s1, bus.s2, bus.s3}), 32'h7);
    check("cmp_sine2",  32'(bus.sine_val_2), 32'h800000);
    check("cmp_lock1",  32'(bus.lock), 32'd0);
    bus.triangle = 24'hFFFFFF;
    bus.power    = 12'd5;
    tick();
    check("boost_freq", 32'(bus.frequency), 32'd5);
    check("cmp_above",  32'({bus.s1, bus.s2, bus.s3}), 32'd0);
    tick();
    check("boost_amp",  32'(bus.amplitude), 32'd205);
    check("boost_mod",  32'(bus.modulation), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
